// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; refills whole lines over a single-word read port.
// Define ICACHE_FLUSH_EN to add the i_flush port and the invalidate-all FLUSH state.
module icache #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_valid
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic        i_flush
`endif
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TW = 30 - IB - OB;
    localparam logic [OB-1:0] LAST = OB'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REFILL
`ifdef ICACHE_FLUSH_EN
        ,
        FLUSH
`endif
    } state_t;

    state_t state, next;

    logic [LINES-1:0] valid;
    logic [31:0]      data_mem [LINES][LINE_WORDS];
    logic [TW-1:0]    tag_mem  [LINES];

    logic [OB-1:0]   off;
    logic [IB-1:0]   idx;
    logic [TW-1:0]   tag;
    logic [29-OB:0]  line_addr;
    logic [IB-1:0]   r_idx;
    logic [TW-1:0]   r_tag;
    logic [OB-1:0]   cnt;
    logic            hit, ack, fill_last, addr_unused;

    assign off         = i_addr[OB+1:2];
    assign idx         = i_addr[IB+OB+1:OB+2];
    assign tag         = i_addr[31:IB+OB+2];
    assign addr_unused = ^i_addr[1:0];

    // line_addr holds {tag, index} of the line in flight; it doubles as the refill base
    assign r_idx = line_addr[IB-1:0];
    assign r_tag = line_addr[29-OB:IB];

    assign hit       = (state == IDLE) && valid[idx] && (tag_mem[idx] == tag);
    assign ack       = (state == REFILL) && i_mem_valid;
    assign fill_last = ack && (cnt == LAST);

`ifdef ICACHE_FLUSH_EN
    logic [IB-1:0] fcnt;
    logic          pend, flush_go;
    assign flush_go = i_flush || pend;
`endif

    always_comb begin
        next       = state;
        o_valid    = 1'b0;
        o_data     = '0;
        o_mem_rd   = 1'b0;
        o_mem_addr = '0;
        case (state)
            IDLE: begin
                o_valid = hit;
                if (hit) o_data = data_mem[idx][off];
`ifdef ICACHE_FLUSH_EN
                if (flush_go) next = FLUSH;
                else
`endif
                if (!hit) next = REFILL;
            end
            REFILL: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = {line_addr, cnt, 2'b00};
                if (fill_last) next = IDLE;
            end
`ifdef ICACHE_FLUSH_EN
            FLUSH: if (fcnt == IB'(LINES - 1)) next = IDLE;
`endif
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            valid <= '0;
            cnt   <= '0;
`ifdef ICACHE_FLUSH_EN
            fcnt  <= '0;
            pend  <= 1'b0;
`endif
        end else begin
            state <= next;
            case (state)
                IDLE: begin
                    // the line is invalid from the moment its refill begins
                    if (next == REFILL) begin
                        valid[idx] <= 1'b0;
                        cnt        <= '0;
                    end
`ifdef ICACHE_FLUSH_EN
                    if (next == FLUSH) begin
                        fcnt <= '0;
                        pend <= 1'b0;
                    end
`endif
                end
                REFILL: begin
                    if (ack)       cnt          <= cnt + 1'b1;
                    if (fill_last) valid[r_idx] <= 1'b1;
`ifdef ICACHE_FLUSH_EN
                    if (i_flush)   pend         <= 1'b1;
`endif
                end
`ifdef ICACHE_FLUSH_EN
                FLUSH: begin
                    valid[fcnt] <= 1'b0;
                    fcnt        <= fcnt + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // storage arrays need no reset; validity is tracked separately
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state == IDLE && next == REFILL) line_addr <= i_addr[31:OB+2];
            if (ack)       data_mem[r_idx][cnt] <= i_mem_data;
            if (fill_last) tag_mem[r_idx]       <= r_tag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: line-level reference model compared every cycle, plus directed literal checks.
module tb_icache;
    localparam int L = 64;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_addr = '0;
    logic [31:0] o_data;
    logic        o_valid;
    logic [31:0] o_mem_addr;
    logic        o_mem_rd;
    logic [31:0] i_mem_data = '0;
    logic        i_mem_valid = 1'b0;
    logic        flush_in = 1'b0;

    int total = 0;
    int bad   = 0;
    int mode  = 0;   // 0: ack every cycle, 1: ack every third refill cycle
    int gen   = 0;   // bumps memory contents so stale data is detectable

    icache dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_addr      (i_addr),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_mem_addr  (o_mem_addr),
        .o_mem_rd    (o_mem_rd),
        .i_mem_data  (i_mem_data),
        .i_mem_valid (i_mem_valid)
`ifdef ICACHE_FLUSH_EN
        ,
        .i_flush     (flush_in)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a, input int g);
        return (((a >> 2) + 32'd1) * 32'h11) + (32'(g) << 24);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // reference model: per-line contents plus the in-flight line transaction
    bit          mvalid [L];
    logic [27:0] mline  [L];
    logic [31:0] mdata  [L][W];
    bit          busy = 0;
    logic [27:0] bline;
    int          bcnt, fleft = 0, rdcnt = 0;
    bit          fpend = 0, armed = 0;
    logic [31:0] bw [W];

    always begin
        logic [5:0]  ai;
        logic        ev, er, mhit;
        logic [31:0] ed, ea;
        @(negedge clk);
        ai   = i_addr[9:4];
        mhit = !busy && fleft == 0 && mvalid[ai] && mline[ai] == i_addr[31:4];
        ev = mhit; ed = mhit ? mdata[ai][i_addr[3:2]] : 32'h0;
        er = busy; ea = busy ? ({bline, 4'h0} + 32'(4 * bcnt)) : 32'h0;
        if (armed) begin
            chk("o_valid", 32'(o_valid), 32'(ev));
            chk("o_data", o_data, ed);
            chk("o_mem_rd", 32'(o_mem_rd), 32'(er));
            chk("o_mem_addr", o_mem_addr, ea);
        end
        if (mode == 1) begin
            if (o_mem_rd) begin
                i_mem_valid = (rdcnt % 3 == 2);
                rdcnt++;
            end else begin
                i_mem_valid = 1'b0;
                rdcnt = 0;
            end
        end else begin
            i_mem_valid = 1'b1;
        end
        i_mem_data = memf(o_mem_addr, gen);
        @(posedge clk);
        ai = i_addr[9:4];
        if (i_rst) begin
            for (int i = 0; i < L; i++) mvalid[i] = 0;
            busy = 0; fleft = 0; fpend = 0; armed = 1;
        end else if (fleft > 0) begin
            mvalid[L - fleft] = 0;
            fleft--;
        end else if (busy) begin
            if (flush_in) fpend = 1;
            if (i_mem_valid) begin
                bw[bcnt] = i_mem_data;
                bcnt++;
                if (bcnt == W) begin
                    mvalid[bline[5:0]] = 1;
                    mline[bline[5:0]]  = bline;
                    for (int i = 0; i < W; i++) mdata[bline[5:0]][i] = bw[i];
                    busy = 0;
                end
            end
        end else if (flush_in || fpend) begin
            fleft = L; fpend = 0;
        end else if (!(mvalid[ai] && mline[ai] == i_addr[31:4])) begin
            busy = 1; bline = i_addr[31:4]; bcnt = 0; mvalid[ai] = 0;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_hit(input int max, input string nm);
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (o_valid) return;
        end
        total++; bad++;
        $display("FAIL %s: timeout waiting for o_valid", nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rdc, z;
        bit found;
        // reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_mem_rd", 32'(o_mem_rd), 32'h0);
        chk("rst_mem_addr", o_mem_addr, 32'h0);
        step(); i_rst = 1'b0;

        // cold miss at 0x0, zero-wait memory
        @(negedge clk);
        chk("cold_idle_rd", 32'(o_mem_rd), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cold_addr", o_mem_addr, 32'(4 * i));
            chk("cold_valid", 32'(o_valid), 32'h0);
        end
        @(negedge clk);
        chk("cold_hit", 32'(o_valid), 32'h1);
        chk("cold_data", o_data, 32'h11);

        // hits on the filled line, low address bits ignored
        step(); i_addr = 32'h8;
        @(negedge clk);
        chk("hit8_valid", 32'(o_valid), 32'h1);
        chk("hit8_data", o_data, 32'h33);
        chk("hit8_rd", 32'(o_mem_rd), 32'h0);
        step(); i_addr = 32'hB;
        @(negedge clk);
        chk("hitB_data", o_data, 32'h33);
        step(); i_addr = 32'hC;
        @(negedge clk);
        chk("hitC_data", o_data, 32'h44);

        // conflict on index 0
        step(); i_addr = 32'h400;
        @(negedge clk);
        chk("conf_miss", 32'(o_valid), 32'h0);
        @(negedge clk);
        chk("conf_addr", o_mem_addr, 32'h400);
        wait_hit(20, "conf_fill");
        chk("conf_data", o_data, 32'h1111);
        step(); i_addr = 32'h0;
        @(negedge clk);
        chk("refetch_miss", 32'(o_valid), 32'h0);
        @(negedge clk);
        chk("refetch_addr", o_mem_addr, 32'h0);
        wait_hit(20, "refetch_fill");
        chk("refetch_data", o_data, 32'h11);

        // wait states: one ack every third cycle
        step(); mode = 1; i_addr = 32'h2008;
        rdc = 0; found = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (o_mem_rd) rdc++;
            if (o_valid) begin found = 1; break; end
        end
        chk("ws_done", 32'(found), 32'h1);
        chk("ws_cycles", 32'(rdc), 32'd12);
        chk("ws_data8", o_data, 32'h8833);
        step(); i_addr = 32'h2000;
        @(negedge clk); chk("ws_data0", o_data, 32'h8811);
        step(); i_addr = 32'h2004;
        @(negedge clk); chk("ws_data4", o_data, 32'h8822);
        step(); i_addr = 32'h200C;
        @(negedge clk); chk("ws_dataC", o_data, 32'h8844);

        // reset after two acknowledges of a refill
        step(); mode = 0; i_addr = 32'h0;
        @(posedge clk);
        @(posedge clk);
        step(); i_rst = 1'b1; gen = 1;
        step(); i_rst = 1'b0;
        @(negedge clk);
        chk("mrst_rd", 32'(o_mem_rd), 32'h0);
        @(negedge clk);
        chk("mrst_restart", o_mem_addr, 32'h0);
        wait_hit(20, "mrst_fill");
        chk("mrst_data0", o_data, 32'h01000011);
        step(); i_addr = 32'h4;
        @(negedge clk);
        chk("mrst_data4", o_data, 32'h01000022);

`ifdef ICACHE_FLUSH_EN
        // flush with line 0 valid
        step(); i_addr = 32'h0; flush_in = 1'b1;
        step(); flush_in = 1'b0;
        z = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_mem_rd) break;
            z++;
        end
        chk("flush_len", 32'(z), 32'd65);
        wait_hit(20, "flush_refill");
        // flush requested mid-refill waits for the line to complete
        step(); i_addr = 32'h400;
        step(); flush_in = 1'b1;
        step(); flush_in = 1'b0;
        wait_hit(200, "flush_pend");
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
